// File: rtl/led_band_fc_sequencer.sv
// SCLK/LAT command sequencer that programs the LED drivers' FC register: FCWRTEN (15), gap (48), WRTFC (5).
// Optional readback phases (READFC 11, RBGAP 48) are built when LED_FC_READBACK_EN is defined.
module led_band_fc_sequencer #(
  parameter int SCLK_HALF  = 2,
  parameter bit AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        SCLK,
  output logic        LAT,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
`ifdef LED_FC_READBACK_EN
  ,
  input  logic        SIN,
  input  logic [47:0] fc_expected,
  output logic [47:0] fc_readback,
  output logic        fc_match
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FCWRTEN = 3'd1,
    S_GAP     = 3'd2,
    S_WRTFC   = 3'd3,
    S_READFC  = 3'd4,
    S_RBGAP   = 3'd5,
    S_FIN     = 3'd6
  } state_e;

  localparam int DIV_W = (SCLK_HALF < 4) ? 2 : $clog2(SCLK_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             lat_q, lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             auto_q;
  logic             start_eff;

  // Per-phase length and successor; a phase ends on the SCLK high->low of its last period.
  logic [5:0] phase_last;
  state_e     phase_next;
  logic       phase_next_lat;

  always_comb begin
    phase_last     = 6'd0;
    phase_next     = S_FIN;
    phase_next_lat = 1'b0;
    case (state_q)
      S_FCWRTEN: begin phase_last = 6'd14; phase_next = S_GAP;   phase_next_lat = 1'b0; end
      S_GAP:     begin phase_last = 6'd47; phase_next = S_WRTFC; phase_next_lat = 1'b1; end
`ifdef LED_FC_READBACK_EN
      S_WRTFC:   begin phase_last = 6'd4;  phase_next = S_READFC; phase_next_lat = 1'b1; end
      S_READFC:  begin phase_last = 6'd10; phase_next = S_RBGAP;  phase_next_lat = 1'b0; end
      S_RBGAP:   begin phase_last = 6'd47; phase_next = S_FIN;    phase_next_lat = 1'b0; end
`else
      S_WRTFC:   begin phase_last = 6'd4;  phase_next = S_FIN;    phase_next_lat = 1'b0; end
`endif
      default:   begin phase_last = 6'd0;  phase_next = S_FIN;    phase_next_lat = 1'b0; end
    endcase
  end

  // Auto-start behaves as a start pulse on the first cycle after reset releases.
  assign start_eff = start | auto_q;

`ifdef LED_FC_READBACK_EN
  logic [47:0] rb_q, rb_d;
  logic        match_q, match_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef LED_FC_READBACK_EN
    rb_d    = rb_q;
    match_d = match_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_eff) begin
          state_d = S_FCWRTEN;
          busy_d  = 1'b1;
          lat_d   = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef LED_FC_READBACK_EN
        match_d = (rb_q == fc_expected);
`endif
      end
      default: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
`ifdef LED_FC_READBACK_EN
          if (state_q == S_RBGAP && !sclk_q) rb_d = {rb_q[46:0], SIN};
`endif
          if (sclk_q) begin
            if (cnt_q == phase_last) begin
              cnt_d   = '0;
              state_d = phase_next;
              lat_d   = phase_next_lat;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      auto_q  <= 1'b0;
    end
  end

`ifdef LED_FC_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_q    <= '0;
      match_q <= 1'b0;
    end else begin
      rb_q    <= rb_d;
      match_q <= match_d;
    end
  end

  assign fc_readback = rb_q;
  assign fc_match    = match_q;
`endif

  assign SCLK      = sclk_q;
  assign LAT       = lat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
